mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 173 +++++++++++++++++
 tb/tb_mc_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: one FSM steps each instruction through
// fetch, decode and a class-specific execute/writeback sequence.
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE,
    RWB, IEXE, IWB, BR, JMP, JAL, JR
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = FETCH;
    PCLoad       = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    JalSig1      = 1'b0;
    MemToReg     = 1'b0;
    JalSig2      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'd0;
    ALUOperation = 3'b000;
    PCSrc        = 2'd0;
    case (state)
      FETCH: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        ALUSrcB      = 2'd1;
        ALUOperation = ALU_ADD;
        PCLoad       = 1'b1;
        state_next   = DECODE;
      end
      DECODE: begin
        // branch target is computed here so BR can take it from ALUOut
        ALUSrcB      = 2'd3;
        ALUOperation = ALU_ADD;
        case (opc)
          6'b000000: begin
            case (func)
              6'b001000: state_next = JR;
              6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010: state_next = REXE;
              default: state_next = FETCH;
            endcase
          end
          6'b100011, 6'b101011: state_next = MEMADR;
          6'b001000, 6'b001010: state_next = IEXE;
          6'b000100, 6'b000101: state_next = BR;
          6'b000010: state_next = JMP;
          6'b000011: state_next = JAL;
          default:   state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'd2;
        ALUOperation = ALU_ADD;
        state_next   = (opc == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REXE: begin
        ALUSrcA    = 1'b1;
        state_next = RWB;
        case (func)
          6'b100000: ALUOperation = ALU_ADD;
          6'b100010: ALUOperation = ALU_SUB;
          6'b100100: ALUOperation = ALU_AND;
          6'b100101: ALUOperation = ALU_OR;
          6'b101010: ALUOperation = ALU_SLT;
          default:   ALUOperation = 3'b000;
        endcase
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      IEXE: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'd2;
        ALUOperation = (opc == 6'b001010) ? ALU_SLT : ALU_ADD;
        state_next   = IWB;
      end
      IWB: RegWrite = 1'b1;
      BR: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'd2;
        PCLoad       = (opc == 6'b000100) ? zero : ~zero;
      end
      JMP: begin
        PCSrc  = 2'd1;
        PCLoad = 1'b1;
      end
      JAL: begin
        JalSig1  = 1'b1;
        JalSig2  = 1'b1;
        RegWrite = 1'b1;
        PCSrc    = 2'd1;
        PCLoad   = 1'b1;
      end
      JR: begin
        PCSrc  = 2'd3;
        PCLoad = 1'b1;
      end
      default: state_next = FETCH;
    endcase
    // reset masks every control so nothing is written while it is held
    if (rst) begin
      PCLoad       = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      JalSig1      = 1'b0;
      MemToReg     = 1'b0;
      JalSig2      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'd0;
      ALUOperation = 3'b000;
      PCSrc        = 2'd0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed and random instructions checked cycle by
// cycle against an instruction-step reference model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc, func;
  logic       zero;
  logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
  logic       MemToReg, JalSig2, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOperation;

  int total = 0;
  int bad   = 0;

  mc_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1), .MemToReg(MemToReg),
    .JalSig2(JalSig2), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc)
  );

  always #5 clk = ~clk;

  // control word: PCLoad IorD MemRead MemWrite IRWrite RegDst JalSig1 MemToReg
  // JalSig2 RegWrite ALUSrcA ALUSrcB[2] ALUOperation[3] PCSrc[2]
  function automatic logic [17:0] pack(
    logic pcl, logic iod, logic mr, logic mw, logic irw, logic rd, logic j1,
    logic m2r, logic j2, logic rw, logic asa, logic [1:0] asb, logic [2:0] op,
    logic [1:0] pcs);
    return {pcl, iod, mr, mw, irw, rd, j1, m2r, j2, rw, asa, asb, op, pcs};
  endfunction

  function automatic logic [17:0] observed();
    return pack(PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1,
                MemToReg, JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc);
  endfunction

  // 0 unsupported, 1 lw, 2 sw, 3 R, 4 imm, 5 branch, 6 j, 7 jal, 8 jr
  function automatic int iclass(logic [5:0] o, logic [5:0] f);
    if (o == 6'b000000) begin
      if (f == 6'b001000) return 8;
      if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return 3;
      return 0;
    end
    if (o == 6'b100011) return 1;
    if (o == 6'b101011) return 2;
    if (o inside {6'b001000, 6'b001010}) return 4;
    if (o inside {6'b000100, 6'b000101}) return 5;
    if (o == 6'b000010) return 6;
    if (o == 6'b000011) return 7;
    return 0;
  endfunction

  function automatic int latency(int c);
    int lat[9] = '{2, 5, 4, 4, 4, 3, 3, 3, 3};
    return lat[c];
  endfunction

  function automatic logic [2:0] rop(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic [17:0] model(logic [5:0] o, logic [5:0] f, int step, logic z);
    int c = iclass(o, f);
    if (step == 0) return pack(1,0,1,0,1,0,0,0,0,0,0,2'd1,3'b010,2'd0);
    if (step == 1) return pack(0,0,0,0,0,0,0,0,0,0,0,2'd3,3'b010,2'd0);
    if (step == 2) begin
      case (c)
        1, 2: return pack(0,0,0,0,0,0,0,0,0,0,1,2'd2,3'b010,2'd0);
        3:    return pack(0,0,0,0,0,0,0,0,0,0,1,2'd0,rop(f),2'd0);
        4:    return pack(0,0,0,0,0,0,0,0,0,0,1,2'd2,(o == 6'b001010) ? 3'b111 : 3'b010,2'd0);
        5:    return pack((o == 6'b000100) ? z : !z,0,0,0,0,0,0,0,0,0,1,2'd0,3'b110,2'd2);
        6:    return pack(1,0,0,0,0,0,0,0,0,0,0,2'd0,3'b000,2'd1);
        7:    return pack(1,0,0,0,0,0,1,0,1,1,0,2'd0,3'b000,2'd1);
        8:    return pack(1,0,0,0,0,0,0,0,0,0,0,2'd0,3'b000,2'd3);
        default: return '0;
      endcase
    end
    if (step == 3) begin
      case (c)
        1: return pack(0,1,1,0,0,0,0,0,0,0,0,2'd0,3'b000,2'd0);
        2: return pack(0,1,0,1,0,0,0,0,0,0,0,2'd0,3'b000,2'd0);
        3: return pack(0,0,0,0,0,1,0,0,0,1,0,2'd0,3'b000,2'd0);
        4: return pack(0,0,0,0,0,0,0,0,0,1,0,2'd0,3'b000,2'd0);
        default: return '0;
      endcase
    end
    if (step == 4 && c == 1) return pack(0,0,0,0,0,0,0,1,0,1,0,2'd0,3'b000,2'd0);
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // entered at posedge+1 with the FSM in FETCH; zsel<0 randomizes zero per cycle
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                           input int stop_at);
    int n = latency(iclass(o, f));
    opc  = o;
    func = f;
    for (int s = 0; s < n; s++) begin
      if (s == stop_at) return;
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      @(negedge clk);
      chk($sformatf("op%b_f%b_s%0d", o, f, s), observed(), model(o, f, s, zero));
      chk("mr_mw_excl", {17'd0, MemRead & MemWrite}, 18'd0);
      chk("rw_mw_excl", {17'd0, RegWrite & MemWrite}, 18'd0);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] opcs [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001010,
                            6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b111111};
  logic [5:0] funcs[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b001000, 6'b000111};

  initial begin
    rst = 1'b1; opc = 6'b100011; func = '0; zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", observed(), 18'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(6'b100011, 6'b000000, -1, -1);   // lw
    run_instr(6'b000000, 6'b100010, -1, -1);   // sub
    run_instr(6'b000100, 6'b000000, 1, -1);    // beq taken
    run_instr(6'b000100, 6'b000000, 0, -1);    // beq not taken
    run_instr(6'b000101, 6'b000000, 1, -1);    // bne
    run_instr(6'b000101, 6'b000000, 0, -1);
    run_instr(6'b000011, 6'b000000, -1, -1);   // jal
    run_instr(6'b000000, 6'b001000, -1, -1);   // jr
    run_instr(6'b111111, 6'b000000, -1, -1);   // unsupported
    run_instr(6'b000000, 6'b111111, -1, -1);   // unsupported func

    // reset during MEMWR of a store
    run_instr(6'b101011, 6'b000000, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_memwr", observed(), 18'd0);
    chk("rst_memwrite", {17'd0, MemWrite}, 18'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(6'b001010, 6'b000000, -1, -1);   // slti right after release

    for (int i = 0; i < 60; i++) begin
      logic [5:0] o, f;
      o = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) o = 6'($urandom);
      f = funcs[$urandom_range(0, 6)];
      run_instr(o, f, -1, -1);
    end
    run_instr(6'b101011, 6'b000000, -1, -1);   // full sw

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
